simple_bus_master: RTL
======================

SIMPLE_BUS_MASTER -- requirements
Module: simple_bus_master

Interface
REQ-001 SHALL have parameter: WBUF_DEPTH, default 16, write-buffer depth in 32-bit words (power of 2, at least 2).
REQ-002 SHALL have parameter: TIMEOUT, default 255, maximum idle cycles waiting for slave response before error.
REQ-003 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-low.
REQ-004 SHALL have command ports: cmd_valid_i in 1; cmd_ready_o out 1; cmd_addr_i in 32 byte address; cmd_readNWrite_i in 1; cmd_burstSize_i in 8 (beats minus 1); cmd_byteEnables_i in 4.
REQ-005 SHALL have write-data ports: wr_data_i in 32; wr_valid_i in 1; wr_ready_o out 1.
REQ-006 SHALL have read-data ports: rd_data_o out 32; rd_valid_o out 1 (no backpressure).
REQ-007 SHALL have status ports: done_o out 1 (one-cycle pulse); error_o out 1 (valid with done_o).
REQ-008 SHALL have arbitration ports: bus_request_o out 1; bus_grant_i in 1.
REQ-009 SHALL have bus outputs: bus_addrData_o 32, bus_byteEnables_o 4, bus_burstSize_o 8, bus_readNWrite_o 1, bus_beginTransaction_o 1, bus_endTransaction_o 1, bus_dataValid_o 1.
REQ-010 SHALL have bus inputs: bus_addrData_i 32, bus_endTransaction_i 1, bus_dataValid_i 1, bus_busy_i 1, bus_error_i 1.

Function
REQ-011 SHALL use FSM states IDLE, REQ, BEGIN, WRITE, READ, DONE.
REQ-012 SHALL assert cmd_ready_o only in IDLE; handshake = cmd_valid_i & cmd_ready_o, latching all cmd fields.
REQ-013 SHALL, for writes, accept cmd_burstSize_i up to WBUF_DEPTH-1; larger values finish immediately with done_o and error_o set, without touching the bus.
REQ-014 SHALL fill write FIFO via wr_valid_i & wr_ready_o; wr_ready_o = FIFO not full, in any state.
REQ-015 SHALL leave IDLE for REQ only when the write FIFO holds burstSize+1 words (write) or immediately (read).
REQ-016 SHALL hold bus_request_o high in REQ; on bus_grant_i high, go to BEGIN.
REQ-017 SHALL, in BEGIN (exactly one cycle), drive bus_beginTransaction_o=1, bus_addrData_o=latched address, plus burstSize, byteEnables, readNWrite.
REQ-018 SHALL, in WRITE, drive one FIFO word per cycle with bus_dataValid_o=1; while bus_busy_i=1, hold the current word and do not pop.
REQ-019 SHALL assert bus_endTransaction_o with the final write beat (beat count = burstSize+1), then go to DONE.
REQ-020 SHALL, in READ, forward every bus_dataValid_i beat as rd_data_o/rd_valid_o in the same cycle (combinational, zero latency).
REQ-021 SHALL finish READ on bus_endTransaction_i with bus_dataValid_i; an early or late end versus burstSize+1 beats SHALL set error.
REQ-022 SHALL reset an 8-bit idle counter on each read beat; TIMEOUT idle cycles ends the transaction with error.
REQ-023 SHALL, on bus_error_i in BEGIN/WRITE/READ, abort to DONE with error; a write abort flushes the unsent words of that burst.
REQ-024 SHALL drive all bus outputs 0 whenever not in BEGIN/WRITE (wired-OR bus).
REQ-025 SHALL pulse done_o for one cycle in DONE, then return to IDLE.
REQ-026 SHALL keep bus_request_o high from REQ through the end of the transaction.
REQ-027 SHALL handle a simultaneous FIFO push and pop as count unchanged; FIFO pointers wrap modulo WBUF_DEPTH.

Reset
REQ-028 SHALL, on rst_i low, asynchronously enter IDLE and drive every output 0 except wr_ready_o=1 and cmd_ready_o=1 after release.
REQ-029 SHALL, on reset mid-transaction, empty the FIFO and zero all counters, with no done_o pulse.

Structure
REQ-030 SHALL place the state enum, DEFAULT_WBUF_DEPTH and DEFAULT_TIMEOUT in shared package simple_bus_pkg.
REQ-031 SHALL implement the write buffer as sub-module simple_bus_fifo (synchronous FIFO with full, empty and count outputs).

Verification
REQ-032 SHALL cover: write burst 4 beats at 0x00000100, grant after 3 cycles -> one begin pulse, 4 dataValid beats, end on beat 4, slave memory holds the data, done_o=1, error_o=0.
REQ-033 SHALL cover: read burst 8 beats, slave returns 0xA0..0xA7 -> rd_valid_o on 8 cycles with matching data, done_o with error_o=0.
REQ-034 SHALL cover: bus_busy_i high for 2 cycles during beat 2 of a write -> beat 2 held steady, total 4 beats, no data loss.
REQ-035 SHALL cover: read with silent slave, TIMEOUT=16 -> done_o with error_o=1 16 cycles after begin.
REQ-036 SHALL cover: write cmd with burstSize=20, WBUF_DEPTH=16 -> immediate done_o with error_o=1, no bus_request_o.
REQ-037 SHALL cover: rst_i low during WRITE beat 2 -> all outputs 0 at once, FIFO empty, cmd_ready_o=1 after release.

Source files
------------

// File: rtl/simple_bus_pkg.sv
// Shared types and defaults for the simple bus master and its write buffer.
package simple_bus_pkg;

  localparam int DEFAULT_WBUF_DEPTH = 16;
  localparam int DEFAULT_TIMEOUT    = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BEGIN,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        rnw;
    logic [7:0]  burst;
    logic [3:0]  be;
  } cmd_t;

endpackage

// File: rtl/simple_bus_fifo.sv
// Write buffer: synchronous FIFO with single-word pop and a bulk drop used
// to discard the unsent tail of an aborted burst.
module simple_bus_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [31:0]              wdata_i,
  input  logic                     pop_i,
  input  logic                     drop_i,
  input  logic [$clog2(DEPTH):0]   drop_n_i,
  output logic [31:0]              rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, rd_amt;
  logic          do_push;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;

  always_comb begin
    rd_amt = '0;
    if (drop_i)                rd_amt = (drop_n_i > cnt_q) ? cnt_q : drop_n_i;
    else if (pop_i && !empty_o) rd_amt = CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the add.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_q + AW'(rd_amt);
      cnt_q    <= cnt_q + CW'(do_push) - rd_amt;
    end
  end

endmodule

// File: rtl/simple_bus_master.sv
// Burst bus master: buffers write data, arbitrates for a wired-OR bus and
// runs one read or write burst per command, reporting done/error.
module simple_bus_master
  import simple_bus_pkg::*;
#(
  parameter int WBUF_DEPTH = DEFAULT_WBUF_DEPTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic        cmd_readNWrite_i,
  input  logic [7:0]  cmd_burstSize_i,
  input  logic [3:0]  cmd_byteEnables_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        done_o,
  output logic        error_o,
  output logic        bus_request_o,
  input  logic        bus_grant_i,
  output logic [31:0] bus_addrData_o,
  output logic [3:0]  bus_byteEnables_o,
  output logic [7:0]  bus_burstSize_o,
  output logic        bus_readNWrite_o,
  output logic        bus_beginTransaction_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  input  logic [31:0] bus_addrData_i,
  input  logic        bus_endTransaction_i,
  input  logic        bus_dataValid_i,
  input  logic        bus_busy_i,
  input  logic        bus_error_i
);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  state_e        state_q;
  cmd_t          cmd_q;
  logic          pending_q, err_q;
  logic [7:0]    beat_q, idle_q;
  logic [CW-1:0] fifo_cnt, drop_n;
  logic [31:0]   fifo_rdata;
  logic          fifo_full, fifo_empty, fifo_pop, fifo_drop;
  logic          in_begin, in_write, in_read;
  logic          last_beat, timeout_hit, words_ready, wr_abort, oversize;
  logic [8:0]    unsent;

  assign in_begin    = (state_q == ST_BEGIN);
  assign in_write    = (state_q == ST_WRITE);
  assign in_read     = (state_q == ST_READ);
  assign last_beat   = (beat_q == cmd_q.burst);
  assign timeout_hit = (idle_q == 8'(TIMEOUT - 1));
  assign words_ready = 32'(fifo_cnt) >= 32'(cmd_q.burst) + 32'd1;
  assign oversize    = 32'(cmd_burstSize_i) > 32'(WBUF_DEPTH - 1);
  assign wr_abort    = bus_error_i || (bus_busy_i && timeout_hit);

  // Beats not yet accepted by the slave, including the one on the bus now.
  assign unsent    = {1'b0, cmd_q.burst} - {1'b0, beat_q} + 9'd1;
  assign drop_n    = CW'(unsent);
  assign fifo_pop  = in_write && !bus_busy_i && !bus_error_i && !fifo_empty;
  assign fifo_drop = in_write && wr_abort;

  simple_bus_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (wr_valid_i),
    .wdata_i  (wr_data_i),
    .pop_i    (fifo_pop),
    .drop_i   (fifo_drop),
    .drop_n_i (drop_n),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_cnt)
  );

  assign cmd_ready_o   = (state_q == ST_IDLE) && !pending_q;
  assign wr_ready_o    = !fifo_full;
  assign done_o        = (state_q == ST_DONE);
  assign error_o       = done_o && err_q;
  assign bus_request_o = (state_q == ST_REQ) || in_begin || in_write || in_read;
  assign rd_valid_o    = in_read && bus_dataValid_i;
  assign rd_data_o     = rd_valid_o ? bus_addrData_i : '0;

  // Everything driven onto the shared bus is zero outside our own tenure.
  assign bus_beginTransaction_o = in_begin;
  assign bus_addrData_o         = in_begin ? cmd_q.addr : (in_write ? fifo_rdata : '0);
  assign bus_byteEnables_o      = in_begin ? cmd_q.be    : '0;
  assign bus_burstSize_o        = in_begin ? cmd_q.burst : '0;
  assign bus_readNWrite_o       = in_begin && cmd_q.rnw;
  assign bus_dataValid_o        = in_write;
  assign bus_endTransaction_o   = in_write && last_beat;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      beat_q    <= '0;
      idle_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_q <= '{addr: cmd_addr_i, rnw: cmd_readNWrite_i,
                       burst: cmd_burstSize_i, be: cmd_byteEnables_i};
            err_q <= 1'b0;
            if (cmd_readNWrite_i) state_q <= ST_REQ;
            else if (oversize) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else pending_q <= 1'b1;
          end else if (pending_q && words_ready) begin
            pending_q <= 1'b0;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          beat_q <= '0;
          idle_q <= '0;
          if (bus_grant_i) state_q <= ST_BEGIN;
        end
        ST_BEGIN: begin
          if (bus_error_i) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idle_q  <= idle_q + 8'd1;
            state_q <= cmd_q.rnw ? ST_READ : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wr_abort) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else if (!bus_busy_i) begin
            idle_q <= '0;
            beat_q <= beat_q + 8'd1;
            if (last_beat) state_q <= ST_DONE;
          end else idle_q <= idle_q + 8'd1;
        end
        ST_READ: begin
          if (bus_error_i || (!bus_dataValid_i && !bus_endTransaction_i && timeout_hit)) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else if (bus_endTransaction_i) begin
            err_q   <= err_q || !bus_dataValid_i || !last_beat;
            state_q <= ST_DONE;
          end else if (bus_dataValid_i) begin
            idle_q <= '0;
            beat_q <= beat_q + 8'd1;
            if (last_beat) err_q <= 1'b1;  // slave ran past the burst length
          end else idle_q <= idle_q + 8'd1;
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
